pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised chain of DEPTH pipeline registers, each WIDTH bits wide, with a valid bit per stage.
//  Each stage has its own stall and flush. Valid-bit bubble insertion and in/out valid-ready handshakes are built in.
//  Generalises the fixed stall/flush pipeline registers of the 5-stage core (F/D/E/M/W).
//  Sits between the hazard unit and the datapath. Exposes per-stage taps for forwarding.
// PARAMETERS
//  WIDTH      32  payload bits per stage
//  DEPTH      4   number of stages (>=1); stage 0 = input side, stage DEPTH-1 = output
//  RESET_VAL  0   payload value loaded into every stage on reset
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            synchronous active-low reset
//  in_valid     in   1            upstream item present
//  in_data      in   WIDTH        upstream payload
//  in_ready     out  1            stage 0 can accept this cycle
//  stall        in   DEPTH        stall[i]: hazard-unit hold request for stage i
//  flush        in   DEPTH        flush[i]: kill content of stage i at next edge
//  out_valid    out  1            valid bit of stage DEPTH-1
//  out_data     out  WIDTH        payload of stage DEPTH-1
//  out_ready    in   1            downstream accepts
//  stage_valid  out  DEPTH        valid bit of every stage (forwarding taps)
//  stage_data   out  DEPTH*WIDTH  payload of stage i on [i*WIDTH +: WIDTH]
//  occupancy    out  $clog2(DEPTH+1)  popcount of stage_valid
// BEHAVIOUR
//  Reset (rst_n=0 at edge): all valid<=0 and all payloads<=RESET_VAL.
//   While rst_n=0: in_ready=0.
//   After reset: out_valid=0, occupancy=0.
//  Hold terms (combinational, computed from output end to input end):
//   hold[DEPTH-1] = stall[DEPTH-1] | (valid[DEPTH-1] & ~out_ready)
//   hold[i]       = stall[i] | (valid[i] & hold[i+1])   (collapse form, see CONFIGURATION)
//  in_ready = rst_n & ~hold[0].
//  Input transfer (in_valid & in_ready): stage 0 loads in_data with valid=1.
//   in_valid=0 & in_ready=1: stage 0 loads a bubble (valid=0, payload unchanged).
//  Stage i>0 with ~hold[i]:
//   if ~hold[i-1]: loads payload and valid of stage i-1.
//   else: loads a bubble (valid<=0, payload unchanged).
//  A stage with hold[i]=1 keeps payload and valid.
//  Output transfer = out_valid & out_ready & ~stall[DEPTH-1].
//  flush[i]=1: valid[i]<=0 at next edge. Flush has priority over hold and load.
//   Payload may still load and is don't-care.
//   An input transfer coincident with flush[0] is a completed handshake; the item is dropped.
//  Latency: item accepted at edge t is on out_data/out_valid after edge t+DEPTH-1.
//   Requires no stalls, flushes or back-pressure.
//   Throughput: 1 item per cycle.
//  No loss or duplication: every accepted, unflushed item leaves exactly once, in order.
//  occupancy: combinational popcount of the registered valid bits.
//   Reaches DEPTH when the chain is full.
//  DEPTH=1: hold[0] uses the last-stage equation; stage 0 is both ends.
// CONFIGURATION
//  PIPE_BUBBLE_COLLAPSE_EN defined:
//   hold[i] as above. An empty stage never blocks upstream.
//   Bubbles are squeezed out under stall or back-pressure.
//  PIPE_BUBBLE_COLLAPSE_EN undefined (lockstep, classic CPU style):
//   hold[i] = stall[i] | hold[i+1] for i<DEPTH-1.
//   hold[DEPTH-1] = stall[DEPTH-1] | ~out_ready.
//   Any downstream hold freezes all upstream stages regardless of valid bits.
// TESTING
//  1. DEPTH=4; in_valid=1 with 0x10..0x13 on 4 consecutive cycles; out_ready=1.
//     -> out_data 0x10..0x13 on cycles t+3..t+6; occupancy peaks at 4; in_ready stays 1.
//  2. Full pipe; stall=4'b0010 for 2 cycles.
//     -> stages 0,1 frozen; stage 2 gets 2 bubbles; in_ready=0 for 2 cycles.
//     -> output sequence continuous after the bubbles; no loss, no duplicate.
//  3. Full pipe holding A,B,C,D (stage 3..0); flush=4'b0011 for 1 cycle.
//     -> C and D never appear; A, B leave in order; occupancy drops by 2.
//  4. Single item in stage 3; out_ready=0 for 5 cycles; in_valid=1.
//     -> collapse_EN: in_ready=1 for 3 cycles until occupancy=4, then 0.
//     -> lockstep: in_ready=0 from the first stall cycle.
//  5. rst_n=0 for 1 cycle mid-stream.
//     -> next cycle: stage_valid=0, out_valid=0, occupancy=0, every stage_data=RESET_VAL.
//     -> in_ready=0 during the reset cycle.
//  6. in_valid=1, data 0xAA, with flush[0]=1 on the same cycle.
//     -> in_ready=1, handshake completes; 0xAA never appears on out_data.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-deep chain of WIDTH-bit pipeline registers with per-stage
// valid, stall and flush, plus in/out valid-ready handshakes and per-stage taps.
// Optional feature macro: PIPE_BUBBLE_COLLAPSE_EN
//   defined   -> empty stages never block upstream; bubbles are squeezed out.
//   undefined -> lockstep: any downstream hold freezes every upstream stage.
module pipe_stage_chain #(
    parameter int unsigned       WIDTH     = 32,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    input  logic [DEPTH-1:0]             stall,
    input  logic [DEPTH-1:0]             flush,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [DEPTH-1:0]             stage_valid,
    output logic [DEPTH*WIDTH-1:0]       stage_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int          LAST  = int'(DEPTH) - 1;

    logic [DEPTH-1:0]  validQ;
    logic [WIDTH-1:0]  dataQ     [DEPTH];
    logic [DEPTH-1:0]  hold;
    logic [DEPTH-1:0]  nextValid;
    logic [WIDTH-1:0]  nextData  [DEPTH];

    // Hold terms ripple from the output end back toward the input end.
    always_comb begin
        hold = '0;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
        hold[LAST] = stall[LAST] | (validQ[LAST] & ~out_ready);
        for (int i = LAST - 1; i >= 0; i--) begin
            hold[i] = stall[i] | (validQ[i] & hold[i+1]);
        end
`else
        hold[LAST] = stall[LAST] | ~out_ready;
        for (int i = LAST - 1; i >= 0; i--) begin
            hold[i] = stall[i] | hold[i+1];
        end
`endif
    end

    // Stage 0 can take a new item whenever it is not held and reset is released.
    always_comb begin
        in_ready = rst_n & ~hold[0];
    end

    // Next-state of every stage: hold, advance, or take a bubble; flush kills the valid bit last.
    always_comb begin
        nextValid = validQ;
        nextData  = dataQ;
        for (int i = 0; i <= LAST; i++) begin
            if (!hold[i]) begin
                if (i == 0) begin
                    nextValid[i] = in_valid;
                    if (in_valid) begin
                        nextData[i] = in_data;
                    end
                end else if (!hold[i-1]) begin
                    nextValid[i] = validQ[i-1];
                    nextData[i]  = dataQ[i-1];
                end else begin
                    // upstream is frozen: insert a bubble, keep the stale payload
                    nextValid[i] = 1'b0;
                end
            end
            if (flush[i]) begin
                nextValid[i] = 1'b0;
            end
        end
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validQ <= '0;
            for (int i = 0; i <= LAST; i++) begin
                dataQ[i] <= RESET_VAL;
            end
        end else begin
            validQ <= nextValid;
            for (int i = 0; i <= LAST; i++) begin
                dataQ[i] <= nextData[i];
            end
        end
    end

    // Popcount of the registered valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i <= LAST; i++) begin
            occupancy = occupancy + OCC_W'(validQ[i]);
        end
    end

    // Output end and forwarding taps come straight from the registers.
    always_comb begin
        out_valid   = validQ[LAST];
        out_data    = dataQ[LAST];
        stage_valid = validQ;
        for (int i = 0; i <= LAST; i++) begin
            stage_data[i*WIDTH +: WIDTH] = dataQ[i];
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios plus random traffic,
// with an item-level reference model and an output scoreboard.
module tb_pipe_stage_chain;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int          LAST  = int'(DEPTH) - 1;
    localparam logic [WIDTH-1:0] RESET_VAL = 32'h0;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic [WIDTH-1:0]       in_data = '0;
    logic                   in_ready;
    logic [DEPTH-1:0]       stall = '0;
    logic [DEPTH-1:0]       flush = '0;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_ready = 1'b0;
    logic [DEPTH-1:0]       stage_valid;
    logic [DEPTH*WIDTH-1:0] stage_data;
    logic [OCC_W-1:0]       occupancy;

    pipe_stage_chain #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .stall       (stall),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    // Items expected to leave the output, oldest first.
    logic [WIDTH-1:0] expQ[$];

    // Reference model: which item (if any) sits in each slot.
    bit               slotFull [DEPTH];
    logic [WIDTH-1:0] slotItem [DEPTH];

    function automatic void checkVal(string name, logic [63:0] act, logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void dropItem(logic [WIDTH-1:0] item);
        int idx[$];
        idx = expQ.find_first_index(x) with (x == item);
        if (idx.size() > 0) expQ.delete(idx[0]);
    endfunction

    function automatic void clearModel();
        for (int i = 0; i <= LAST; i++) begin
            slotFull[i] = 1'b0;
            slotItem[i] = RESET_VAL;
        end
        expQ.delete();
    endfunction

    // Monitor: every output transfer must deliver the oldest outstanding item.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !stall[DEPTH-1]) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("FAIL out_data: got 0x%0h, expected no item at %0t", out_data, $time);
            end else begin
                checkVal("out_data", 64'(out_data), 64'(expQ.pop_front()));
            end
        end
    end

    // Evaluate the current inputs against the model, check visible state, then advance the model.
    task automatic modelStep();
        bit               blocked [DEPTH];
        bit               nFull   [DEPTH];
        logic [WIDTH-1:0] nItem   [DEPTH];
        logic [DEPTH-1:0] validVec;
        int               count;
        bit               downBlocked;

        // A stage is blocked by its own stall or by pressure from below.
        for (int i = LAST; i >= 0; i--) begin
            if (i == LAST) downBlocked = !out_ready;
            else           downBlocked = blocked[i+1];
`ifdef PIPE_BUBBLE_COLLAPSE_EN
            blocked[i] = stall[i] || (slotFull[i] && downBlocked);
`else
            blocked[i] = stall[i] || downBlocked;
`endif
        end

        count = 0;
        for (int i = 0; i <= LAST; i++) begin
            validVec[i] = slotFull[i];
            if (slotFull[i]) count++;
        end
        checkVal("in_ready",    64'(in_ready),    64'(!blocked[0]));
        checkVal("occupancy",   64'(occupancy),   64'(count));
        checkVal("out_valid",   64'(out_valid),   64'(slotFull[LAST]));
        checkVal("stage_valid", 64'(stage_valid), 64'(validVec));

        if (in_valid && !blocked[0]) expQ.push_back(in_data);

        for (int i = 0; i <= LAST; i++) begin
            if (blocked[i]) begin
                nFull[i] = slotFull[i];
                nItem[i] = slotItem[i];
            end else if (i == 0) begin
                nFull[i] = in_valid;
                nItem[i] = in_valid ? in_data : slotItem[i];
            end else if (!blocked[i-1]) begin
                nFull[i] = slotFull[i-1];
                nItem[i] = slotItem[i-1];
            end else begin
                nFull[i] = 1'b0;
                nItem[i] = slotItem[i];
            end
            if (flush[i] && nFull[i]) begin
                dropItem(nItem[i]);
                nFull[i] = 1'b0;
            end
        end
        for (int i = 0; i <= LAST; i++) begin
            slotFull[i] = nFull[i];
            slotItem[i] = nItem[i];
        end
    endtask

    task automatic cycle(input bit iv, input logic [WIDTH-1:0] id, input logic [DEPTH-1:0] st,
                         input logic [DEPTH-1:0] fl, input bit ordy);
        in_valid  = iv;
        in_data   = id;
        stall     = st;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, '0, 1'b1);
    endtask

    // One-cycle reset with traffic still applied; checks the cleared state afterwards.
    task automatic doReset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_0001;
        @(negedge clk);
        checkVal("in_ready_in_reset", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        checkVal("rst_stage_valid", 64'(stage_valid), 64'(0));
        checkVal("rst_out_valid",   64'(out_valid),   64'(0));
        checkVal("rst_occupancy",   64'(occupancy),   64'(0));
        for (int i = 0; i <= LAST; i++) begin
            checkVal("rst_stage_data", 64'(stage_data[i*WIDTH +: WIDTH]), 64'(RESET_VAL));
        end
        clearModel();
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        int unsigned seq;
        logic [DEPTH-1:0] st;
        logic [DEPTH-1:0] fl;

        clearModel();
        repeat (2) @(posedge clk);
        #1;
        doReset();

        // Four back-to-back items stream through at full rate.
        for (int k = 0; k < 4; k++) cycle(1'b1, 32'h10 + 32'(k), '0, '0, 1'b1);
        idle(6);

        // Full pipe with stage 1 stalled for two cycles.
        for (int k = 0; k < 4; k++) cycle(1'b1, 32'h20 + 32'(k), '0, '0, 1'b1);
        cycle(1'b1, 32'h24, 4'b0010, '0, 1'b1);
        cycle(1'b1, 32'h25, 4'b0010, '0, 1'b1);
        for (int k = 6; k < 9; k++) cycle(1'b1, 32'h20 + 32'(k), '0, '0, 1'b1);
        idle(8);

        // Full pipe A,B,C,D held by the sink; flush the two input-side stages.
        for (int k = 0; k < 4; k++) cycle(1'b1, 32'hA0 + 32'(k), '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 4'b0011, 1'b0);
        checkVal("flush_occupancy", 64'(occupancy), 64'(2));
        idle(6);

        // Lone item at the output, sink back-pressure for five cycles, source keeps offering.
        cycle(1'b1, 32'h40, '0, '0, 1'b1);
        idle(3);
        for (int k = 1; k <= 5; k++) cycle(1'b1, 32'h40 + 32'(k), '0, '0, 1'b0);
        idle(8);

        // Input handshake coincident with a stage-0 flush drops the item.
        cycle(1'b1, 32'hAA, '0, 4'b0001, 1'b1);
        idle(6);

        // Random traffic with a reset in the middle of the stream.
        seq = 1;
        for (int k = 0; k < 1500; k++) begin
            if (k == 750) doReset();
            st = '0;
            fl = '0;
            for (int i = 0; i <= LAST; i++) begin
                st[i] = ($urandom_range(0, 9) == 0);
                if (i < LAST) fl[i] = ($urandom_range(0, 19) == 0);
            end
            cycle(($urandom_range(0, 9) < 7), {16'(seq), 16'($urandom)}, st, fl,
                  ($urandom_range(0, 3) != 0));
            seq++;
        end

        idle(DEPTH + 4);
        checkVal("drain_outstanding", 64'(expQ.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
